neo_68k_busmaster: RTL and testbench

- 68000-style bus cycle initiator: turns a simple single-word request into a real 68k bus cycle (nAS, nUDS/nLDS, RW, address, data).
- Waits for nDTACK from the address decoder / wait generator, then returns read data or write completion.
- Sits between a requesting agent (boot loader, debug port or DMA helper) and the same 68k bus that the decoder and wait logic observe.
- Timing is paced by the existing 68k phase enables, so cycles look identical to CPU cycles.

---
 rtl/neo_bus_pkg.sv | 38 +++
 rtl/neo_bus_timeout.sv | 35 +++
 rtl/neo_68k_busmaster.sv | 175 +++++++++++++++++
 tb/tb_neo_68k_busmaster.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neo_bus_pkg.sv
// ============================================================================
// Module : neo_bus_pkg
// Brief  : Shared state codes, byte-enable encodings and defaults for the
//          68000-style bus master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package neo_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S0   = 3'd1,
        ST_S2   = 3'd2,
        ST_S4   = 3'd3,
        ST_S6   = 3'd4,
        ST_S7   = 3'd5
    } bus_state_t;

    localparam logic [1:0] BE_UPPER = 2'b10;
    localparam logic [1:0] BE_LOWER = 2'b01;
    localparam logic [1:0] BE_WORD  = 2'b11;

    localparam int C_TIMEOUT_CYCLES = 255;

    // A byte write mirrors the selected byte onto both lanes, like a real 68000.
    function automatic logic [15:0] bus_wdata(input logic [1:0] be, input logic [15:0] d);
        case (be)
            BE_UPPER: return {d[15:8], d[15:8]};
            BE_LOWER: return {d[7:0], d[7:0]};
            BE_WORD:  return d;
            default:  return d;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/neo_bus_timeout.sv
// ============================================================================
// Module : neo_bus_timeout
// Brief  : Enable-gated up-counter with synchronous clear and a terminal flag
//          that fires on the MAX_COUNT-th enabled pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module neo_bus_timeout #(
    parameter int MAX_COUNT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && !terminal) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign terminal = en && (r_count == CW'(MAX_COUNT - 1));

endmodule

`default_nettype wire

// File: rtl/neo_68k_busmaster.sv
// ============================================================================
// Module : neo_68k_busmaster
// Brief  : Turns a single-word request into a 68000 bus cycle paced by the
//          68k phase enables. Optional macro BUSMASTER_TIMEOUT_EN adds a
//          DTACK timeout that aborts the cycle with BERR.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module neo_68k_busmaster
    import neo_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLK_EN_68K_P,
    input  logic        CLK_EN_68K_N,
    input  logic        REQ,
    input  logic [22:0] REQ_ADDR,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_BE,
    input  logic [15:0] REQ_WDATA,
    output logic        BUSY,
    output logic        ACK,
    output logic        BERR,
    output logic [15:0] RDATA,
    output logic [22:0] M68K_ADDR,
    output logic [15:0] M68K_DATA_OUT,
    output logic        M68K_DATA_OE,
    output logic        RW,
    output logic        nAS,
    output logic        nUDS,
    output logic        nLDS,
    input  logic        nDTACK,
    input  logic [15:0] M68K_DATA_IN
);

    bus_state_t  r_state;
    logic [22:0] r_addr;
    logic        r_we;
    logic [1:0]  r_be;
    logic [15:0] r_wdata;
    logic        r_timed_out;

    logic w_p;
    logic w_n;
    logic w_to;

    // P wins when both enables land in the same clock.
    assign w_p = CLK_EN_68K_P;
    assign w_n = CLK_EN_68K_N & ~CLK_EN_68K_P;

`ifdef BUSMASTER_TIMEOUT_EN
    neo_bus_timeout #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (CLK),
        .rst      (RESET),
        .clr      (r_state != ST_S4),
        .en       (w_p && (r_state == ST_S4)),
        .terminal (w_to)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign w_to = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_timed_out   <= 1'b0;
            nAS           <= 1'b1;
            nUDS          <= 1'b1;
            nLDS          <= 1'b1;
            RW            <= 1'b1;
            M68K_DATA_OE  <= 1'b0;
            M68K_ADDR     <= '0;
            M68K_DATA_OUT <= '0;
            RDATA         <= '0;
            BUSY          <= 1'b0;
            ACK           <= 1'b0;
            BERR          <= 1'b0;
        end else begin
            ACK  <= 1'b0;
            BERR <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (REQ && (REQ_BE != 2'b00)) begin
                        r_addr      <= REQ_ADDR;
                        r_we        <= REQ_WE;
                        r_be        <= REQ_BE;
                        r_wdata     <= REQ_WDATA;
                        r_timed_out <= 1'b0;
                        BUSY        <= 1'b1;
                        r_state     <= ST_S0;
                    end
                end
                ST_S0: begin
                    if (w_p) begin
                        M68K_ADDR <= r_addr;
                        RW        <= ~r_we;
                        r_state   <= ST_S2;
                    end
                end
                ST_S2: begin
                    if (w_n) begin
                        nAS <= 1'b0;
                        if (r_we) begin
                            M68K_DATA_OE  <= 1'b1;
                            M68K_DATA_OUT <= bus_wdata(r_be, r_wdata);
                        end else begin
                            nUDS <= ~r_be[1];
                            nLDS <= ~r_be[0];
                        end
                        r_state <= ST_S4;
                    end
                end
                ST_S4: begin
                    if (w_n && r_we) begin
                        nUDS <= ~r_be[1];
                        nLDS <= ~r_be[0];
                    end
                    if (w_p) begin
                        if (!nDTACK) begin
                            r_state <= ST_S6;
                        end else if (w_to) begin
                            r_timed_out <= 1'b1;
                            if (!r_we) begin
                                RDATA <= 16'hFFFF;
                            end
                            r_state <= ST_S7;
                        end
                    end
                end
                ST_S6: begin
                    // A zero-wait write reaches here before its S4 N-phase, so strobe now.
                    if (w_n) begin
                        if (r_we) begin
                            nUDS <= ~r_be[1];
                            nLDS <= ~r_be[0];
                        end else begin
                            RDATA <= M68K_DATA_IN;
                        end
                        r_state <= ST_S7;
                    end
                end
                ST_S7: begin
                    if (w_p) begin
                        nAS          <= 1'b1;
                        nUDS         <= 1'b1;
                        nLDS         <= 1'b1;
                        M68K_DATA_OE <= 1'b0;
                        RW           <= 1'b1;
                        ACK          <= 1'b1;
                        BERR         <= r_timed_out;
                        BUSY         <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_neo_68k_busmaster.sv
// ============================================================================
// Module : tb_neo_68k_busmaster
// Brief  : Directed self-checking bench for the 68000-style bus master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_neo_68k_busmaster;

    logic        clk;
    logic        rst;
    logic        en_p;
    logic        en_n;
    logic        req;
    logic [22:0] req_addr;
    logic        req_we;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        busy;
    logic        ack;
    logic        berr;
    logic [15:0] rdata;
    logic [22:0] m_addr;
    logic [15:0] dout;
    logic        oe;
    logic        rw;
    logic        nas;
    logic        nuds;
    logic        nlds;
    logic        ndtack;
    logic [15:0] din;

    int checks   = 0;
    int failures = 0;

    neo_68k_busmaster #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK           (clk),
        .RESET         (rst),
        .CLK_EN_68K_P  (en_p),
        .CLK_EN_68K_N  (en_n),
        .REQ           (req),
        .REQ_ADDR      (req_addr),
        .REQ_WE        (req_we),
        .REQ_BE        (req_be),
        .REQ_WDATA     (req_wdata),
        .BUSY          (busy),
        .ACK           (ack),
        .BERR          (berr),
        .RDATA         (rdata),
        .M68K_ADDR     (m_addr),
        .M68K_DATA_OUT (dout),
        .M68K_DATA_OE  (oe),
        .RW            (rw),
        .nAS           (nas),
        .nUDS          (nuds),
        .nLDS          (nlds),
        .nDTACK        (ndtack),
        .M68K_DATA_IN  (din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 68k phase enables: one P and one N per 8 CLKs; a pending both-request
    // makes the next P pulse carry N as well.
    int both_req  = 0;
    int both_done = 0;
    initial begin
        int ph;
        ph   = 0;
        en_p = 1'b0;
        en_n = 1'b0;
        forever begin
            @(negedge clk);
            en_p = (ph == 0);
            en_n = (ph == 4) || (ph == 0 && both_req != both_done);
            if (ph == 0 && both_req != both_done) both_done++;
            ph = (ph + 1) % 8;
        end
    end

    // Bus monitor
    int          acks       = 0;
    int          busy_rises = 0;
    int          pcnt       = 0;
    bit          counting   = 0;
    bit          prev_busy  = 0;
    bit          saw_uds, saw_lds, saw_rw_low, order_err, ack_berr;
    logic [22:0] cap_addr   = '0;
    logic [15:0] cap_dout   = '0;

    always @(posedge clk) begin
        #1;
        if (ack === 1'b1) begin
            acks++;
            ack_berr = berr;
        end
        if (busy === 1'b1 && !prev_busy) begin
            busy_rises++;
            counting   = 1;
            pcnt       = 0;
            saw_uds    = 0;
            saw_lds    = 0;
            saw_rw_low = 0;
            order_err  = 0;
            cap_dout   = '0;
        end else if (counting) begin
            if (en_p) pcnt++;
            if (ack === 1'b1) counting = 0;
        end
        prev_busy = (busy === 1'b1);
        if (nuds === 1'b0) saw_uds = 1;
        if (nlds === 1'b0) saw_lds = 1;
        if ((nuds === 1'b0 || nlds === 1'b0) && nas === 1'b1) order_err = 1;
        if (nas === 1'b0) begin
            cap_addr = m_addr;
            if (rw === 1'b0) saw_rw_low = 1;
        end
        if (oe === 1'b1 && (nuds === 1'b0 || nlds === 1'b0)) cap_dout = dout;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [22:0] a, input logic we, input logic [1:0] be, input logic [15:0] wd);
        @(negedge clk);
        req       = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_be    = be;
        req_wdata = wd;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_ack(input string tag);
        int start;
        int n;
        start = acks;
        n     = 0;
        while (acks == start && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (acks == start) check_val({tag, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_nas_low(input string tag);
        int n;
        n = 0;
        while (nas !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (nas !== 1'b0) check_val({tag, "_nas_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic check_idle_bus(input string tag);
        check_val(tag, {27'd0, nas, nuds, nlds, oe, rw}, 32'b11101);
    endtask

    initial begin
        int a0;
        int b0;
        int n;
        rst       = 1'b1;
        req       = 1'b0;
        req_addr  = '0;
        req_we    = 1'b0;
        req_be    = 2'b00;
        req_wdata = '0;
        ndtack    = 1'b1;
        din       = '0;
        repeat (4) @(negedge clk);

        // Reset state
        check_idle_bus("rst_bus");
        check_val("rst_addr",  {9'd0, m_addr}, 32'd0);
        check_val("rst_dout",  {16'd0, dout}, 32'd0);
        check_val("rst_rdata", {16'd0, rdata}, 32'd0);
        check_val("rst_flags", {29'd0, busy, ack, berr}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Zero-wait word read (DTACK already low before S4)
        ndtack = 1'b0;
        din    = 16'hA55A;
        issue(23'h080000, 1'b0, 2'b11, 16'h0000);
        wait_ack("rd_word");
        check_val("rd_word_rdata", {16'd0, rdata}, 32'h0000_A55A);
        check_val("rd_word_addr",  {9'd0, cap_addr}, 32'h0008_0000);
        check_val("rd_word_strb",  {30'd0, saw_uds, saw_lds}, 32'd3);
        check_val("rd_word_rwlow", {31'd0, saw_rw_low}, 32'd0);
        check_val("rd_word_berr",  {31'd0, ack_berr}, 32'd0);
        check_val("rd_word_pcnt",  pcnt, 32'd3);
        check_val("rd_word_order", {31'd0, order_err}, 32'd0);
        check_idle_bus("rd_word_end");
        repeat (10) @(negedge clk);
        check_val("addr_hold", {9'd0, m_addr}, 32'h0008_0000);

        // Lower byte write, DTACK high for three sampled P-phases
        ndtack = 1'b1;
        issue(23'h000123, 1'b1, 2'b01, 16'h1234);
        wait_nas_low("wr_lo");
        n = 0;
        while (n < 3) begin
            @(posedge clk);
            if (en_p) n++;
        end
        @(negedge clk);
        ndtack = 1'b0;
        wait_ack("wr_lo");
        ndtack = 1'b1;
        check_val("wr_lo_dout",  {16'd0, cap_dout}, 32'h0000_3434);
        check_val("wr_lo_strb",  {30'd0, saw_uds, saw_lds}, 32'd1);
        check_val("wr_lo_rwlow", {31'd0, saw_rw_low}, 32'd1);
        check_val("wr_lo_pcnt",  pcnt, 32'd6);
        check_val("wr_lo_order", {31'd0, order_err}, 32'd0);
        check_val("wr_lo_addr",  {9'd0, cap_addr}, 32'h0000_0123);
        check_idle_bus("wr_lo_end");

        // Zero-wait upper byte write
        ndtack = 1'b0;
        issue(23'h000200, 1'b1, 2'b10, 16'hABCD);
        wait_ack("wr_hi");
        check_val("wr_hi_dout",  {16'd0, cap_dout}, 32'h0000_ABAB);
        check_val("wr_hi_strb",  {30'd0, saw_uds, saw_lds}, 32'd2);
        check_val("wr_hi_pcnt",  pcnt, 32'd3);
        check_val("wr_hi_order", {31'd0, order_err}, 32'd0);

        // Reset pulsed while waiting in S4
        ndtack = 1'b1;
        din    = 16'h0000;
        a0     = acks;
        issue(23'h000300, 1'b0, 2'b11, 16'h0000);
        wait_nas_low("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_bus", {27'd0, nas, nuds, nlds, oe, busy}, 32'b11100);
        repeat (48) @(negedge clk);
        check_val("mid_rst_noack", acks - a0, 32'd0);
        ndtack = 1'b0;
        din    = 16'h1357;
        issue(23'h7FFFFF, 1'b0, 2'b11, 16'h0000);
        wait_ack("post_rst");
        check_val("post_rst_rdata", {16'd0, rdata}, 32'h0000_1357);
        check_val("post_rst_addr",  {9'd0, cap_addr}, 32'h007F_FFFF);

        // REQ while BUSY, then REQ with BE=0: both ignored
        ndtack = 1'b1;
        din    = 16'h0BEE;
        a0     = acks;
        b0     = busy_rises;
        issue(23'h000010, 1'b0, 2'b11, 16'h0000);
        wait_nas_low("busy_req");
        issue(23'h000020, 1'b1, 2'b11, 16'hFFFF);
        @(negedge clk);
        ndtack = 1'b0;
        wait_ack("busy_req");
        ndtack = 1'b1;
        check_val("busy_req_rdata", {16'd0, rdata}, 32'h0000_0BEE);
        check_val("busy_req_addr",  {9'd0, cap_addr}, 32'h0000_0010);
        issue(23'h000030, 1'b0, 2'b00, 16'h0000);
        repeat (40) @(negedge clk);
        check_val("ignored_acks",  acks - a0, 32'd1);
        check_val("ignored_busy",  busy_rises - b0, 32'd1);

        // P and N in the same CLK while in S0
        ndtack = 1'b0;
        din    = 16'h5AA5;
        do @(posedge clk); while (!en_p);
        issue(23'h000400, 1'b0, 2'b11, 16'h0000);
        both_req++;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(en_p && en_n) && n < 40);
        @(negedge clk);
        check_val("both_en_nas_hi", {31'd0, nas}, 32'd1);
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!en_n && n < 40);
        @(negedge clk);
        check_val("both_en_nas_lo", {31'd0, nas}, 32'd0);
        wait_ack("both_en");
        check_val("both_en_rdata", {16'd0, rdata}, 32'h0000_5AA5);
        check_val("both_en_pcnt",  pcnt, 32'd3);
        check_val("both_en_order", {31'd0, order_err}, 32'd0);

`ifdef BUSMASTER_TIMEOUT_EN
        // DTACK stuck high: aborted after 8 P-phases in S4
        ndtack = 1'b1;
        din    = 16'h2222;
        issue(23'h000500, 1'b0, 2'b11, 16'h0000);
        wait_ack("tmo");
        check_val("tmo_berr",  {31'd0, ack_berr}, 32'd1);
        check_val("tmo_rdata", {16'd0, rdata}, 32'h0000_FFFF);
        check_val("tmo_pcnt",  pcnt, 32'd10);
        check_idle_bus("tmo_end");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
